alu_seq: RTL and testbench

//  Parametrised multi-cycle ALU, successor to the 16-bit combinational ALU. Adds

---
 rtl/alu_seq.sv | 127 ++++++++++++
 tb/tb_alu_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes on both sides.
// MUL runs as an iterative shift-add; all other ops complete in a single cycle.
module alu_seq #(
  parameter int WIDTH          = 16,
  parameter bit MUL_EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_func,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             alu_zero,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_SLT  = 3'b011;
  localparam logic [2:0] OP_SLTS = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    MUL_BUSY,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0] op_result;
  logic             accept;
  logic             mul_last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid & in_ready;

  // Early exit looks at the multiplier as it will be after this step's shift.
  assign acc_sum  = mplier[0] ? (acc + mcand) : acc;
  assign mul_last = (cnt == CNT_LAST) || (MUL_EARLY_EXIT && ((mplier >> 1) == '0));

  always_comb begin
    op_result = '0;
    case (alu_func)
      OP_ADD:  op_result = src_a + src_b;
      OP_SUB:  op_result = src_a - src_b;
      OP_SLT:  op_result = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      OP_SLTS: op_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_AND:  op_result = src_a & src_b;
      OP_OR:   op_result = src_a | src_b;
      OP_XOR:  op_result = src_a ^ src_b;
      default: op_result = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept) state_next = (alu_func == OP_MUL) ? MUL_BUSY : DONE;
      MUL_BUSY: if (mul_last) state_next = DONE;
      DONE:     if (out_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Result stays registered across DONE->IDLE so the last value remains visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
      alu_result <= '0;
      alu_zero   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (alu_func == OP_MUL) begin
              acc    <= '0;
              mcand  <= src_a;
              mplier <= src_b;
              cnt    <= '0;
            end else begin
              alu_result <= op_result;
              alu_zero   <= (op_result == '0);
            end
          end
        end
        MUL_BUSY: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (mul_last) begin
            alu_result <= acc_sum;
            alu_zero   <= (acc_sum == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=16, MUL_EARLY_EXIT=1): expectations are
// queued at accept and popped when the matching result shows up.
module tb_alu_seq;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    int           lat;
  } exp_t;

  typedef struct {
    logic [2:0]   func;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   alu_func = 3'b000;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] alu_result;
  logic         alu_zero;
  logic         busy;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  alu_seq #(.WIDTH(W), .MUL_EARLY_EXIT(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_func(alu_func), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, need finished");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [W-1:0] ref_alu(input logic [2:0] f, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    int sa;
    int sb_i;
    sa   = (a[W-1]) ? int'(a) - (1 << W) : int'(a);
    sb_i = (b[W-1]) ? int'(b) - (1 << W) : int'(b);
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (f)
      3'd0: return W'(int'(a) + int'(b));
      3'd1: return W'(int'(a) - int'(b));
      3'd2: return prod[W-1:0];
      3'd3: return (int'(a) < int'(b)) ? W'(1) : W'(0);
      3'd4: return (sa < sb_i) ? W'(1) : W'(0);
      3'd5: return a & b;
      3'd6: return a | b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [W-1:0] b);
    int hi;
    if (f != 3'd2) return 1;
    hi = -1;
    for (int i = 0; i < W; i++) if (b[i]) hi = i;
    return 1 + ((hi + 1) > 1 ? (hi + 1) : 1);
  endfunction

  // Drives one request from a negedge and returns at the negedge after acceptance.
  task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       output bit timed_out);
    exp_t e;
    int   n;
    alu_func = f; src_a = a; src_b = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    timed_out = !in_ready;
    e.res  = ref_alu(f, a, b);
    e.zero = (e.res == '0);
    e.lat  = ref_lat(f, b);
    if (!timed_out) sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat, output bit timed_out);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    timed_out = !out_valid;
  endtask

  task automatic consume;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || alu_result !== '0 || alu_zero !== 1'b1 || busy !== 1'b0 ||
        in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset: got ov=%b res=%h z=%b busy=%b rdy=%b, need 0 0000 1 0 1",
               out_valid, alu_result, alu_zero, busy, in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ops;
    vec_t vt[$];
    exp_t e;
    int   lat;
    bit   to_i;
    bit   to_o;
    vt = '{
      '{3'd0, 16'hFFFF, 16'h0002}, '{3'd1, 16'h0005, 16'h0005},
      '{3'd3, 16'hFFFF, 16'h0001}, '{3'd4, 16'hFFFF, 16'h0001},
      '{3'd2, 16'h0003, 16'h0005}, '{3'd2, 16'hFFFF, 16'hFFFF},
      '{3'd2, 16'h1234, 16'h0000}, '{3'd2, 16'h0000, 16'h0001},
      '{3'd1, 16'h0000, 16'h0001}, '{3'd4, 16'h8000, 16'h7FFF},
      '{3'd3, 16'h7FFF, 16'h8000}, '{3'd5, 16'hF0F0, 16'h3C3C},
      '{3'd6, 16'hF0F0, 16'h0F0F}, '{3'd7, 16'hAAAA, 16'hAAAA}
    };
    for (int i = 0; i < 24; i++) begin
      vec_t r;
      r.func = 3'($urandom_range(0, 7));
      r.a    = 16'($urandom);
      r.b    = 16'($urandom);
      vt.push_back(r);
    end
    foreach (vt[i]) begin
      issue(vt[i].func, vt[i].a, vt[i].b, to_i);
      wait_result(lat, to_o);
      vectors++;
      if (to_i || to_o || sb.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL op%0d handshake: got timeout in=%b out=%b q=%0d, need none",
                 i, to_i, to_o, sb.size());
      end else begin
        e = sb.pop_front();
        if (alu_result !== e.res || alu_zero !== e.zero) begin
          miscompares++;
          $display("[TB] FAIL op%0d f=%0d a=%h b=%h: got %h z=%b, need %h z=%b",
                   i, vt[i].func, vt[i].a, vt[i].b, alu_result, alu_zero, e.res, e.zero);
        end
        vectors++;
        if (lat != e.lat) begin
          miscompares++;
          $display("[TB] FAIL op%0d latency: got %0d, need %0d", i, lat, e.lat);
        end
      end
      consume();
    end
  endtask

  task automatic test_backpressure;
    exp_t         e;
    int           lat;
    bit           to_i;
    bit           to_o;
    logic [W-1:0] held;
    issue(3'd0, 16'h1200, 16'h0034, to_i);
    wait_result(lat, to_o);
    e = (sb.size() != 0) ? sb.pop_front() : '{res: 'x, zero: 1'bx, lat: 0};
    held = e.res;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (to_o || out_valid !== 1'b1 || alu_result !== held || in_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL backpressure c%0d: got ov=%b res=%h rdy=%b, need 1 %h 0",
                 i, out_valid, alu_result, in_ready, held);
      end
      @(negedge clk);
    end
    consume();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_result !== held) begin
      miscompares++;
      $display("[TB] FAIL release: got ov=%b rdy=%b res=%h, need 0 1 %h",
               out_valid, in_ready, alu_result, held);
    end
  endtask

  task automatic test_busy_reject;
    exp_t e;
    int   lat;
    bit   to_i;
    bit   to_o;
    issue(3'd2, 16'hFFFF, 16'hFFFF, to_i);
    alu_func = 3'd0; src_a = 16'h0002; src_b = 16'h0003; in_valid = 1'b1;
    lat = 1;
    while (!out_valid && lat < 200) begin
      vectors++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL busy_reject c%0d: got rdy=%b busy=%b, need 0 1", lat, in_ready, busy);
      end
      @(negedge clk);
      lat++;
    end
    e = (sb.size() != 0) ? sb.pop_front() : '{res: 'x, zero: 1'bx, lat: 0};
    vectors++;
    if (!out_valid || alu_result !== 16'h0001 || lat != 17) begin
      miscompares++;
      $display("[TB] FAIL busy_mul: got ov=%b res=%h lat=%0d, need 1 0001 17",
               out_valid, alu_result, lat);
    end
    consume();
    issue(3'd0, 16'h0002, 16'h0003, to_i);
    wait_result(lat, to_o);
    e = (sb.size() != 0) ? sb.pop_front() : '{res: 'x, zero: 1'bx, lat: 0};
    vectors++;
    if (to_o || alu_result !== e.res || lat != 1) begin
      miscompares++;
      $display("[TB] FAIL busy_retry: got res=%h lat=%0d, need %h 1", alu_result, lat, e.res);
    end
    consume();
  endtask

  task automatic test_reset_mid_mul;
    exp_t e;
    int   lat;
    bit   to_i;
    bit   to_o;
    issue(3'd2, 16'h1234, 16'h8000, to_i);
    repeat (6) @(negedge clk);
    if (sb.size() != 0) e = sb.pop_back();
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || alu_result !== '0 || in_ready !== 1'b1 || alu_zero !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_mul: got ov=%b res=%h rdy=%b z=%b, need 0 0000 1 1",
               out_valid, alu_result, in_ready, alu_zero);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(3'd0, 16'h0001, 16'h0001, to_i);
    wait_result(lat, to_o);
    e = (sb.size() != 0) ? sb.pop_front() : '{res: 'x, zero: 1'bx, lat: 0};
    vectors++;
    if (to_o || alu_result !== 16'h0002 || alu_zero !== 1'b0 || lat != 1) begin
      miscompares++;
      $display("[TB] FAIL post_reset_add: got res=%h z=%b lat=%0d, need 0002 0 1",
               alu_result, alu_zero, lat);
    end
    consume();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_ops();
    test_backpressure();
    test_busy_reject();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
